// File: rtl/imuldiv_pkg.sv
// Shared definitions for the imuldiv iterative divider: FSM encoding, fn codes,
// result field positions and the iteration count.
package imuldiv_pkg;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

    localparam logic DIV_FN_UNSIGNED = 1'b0;
    localparam logic DIV_FN_SIGNED   = 1'b1;

    localparam int DIV_W       = 32;
    localparam int RES_QUO_LSB = 0;
    localparam int RES_QUO_MSB = 31;
    localparam int RES_REM_LSB = 32;
    localparam int RES_REM_MSB = 63;

    localparam int               DIV_CNT_W = 6;
    localparam logic [DIV_CNT_W-1:0] DIV_ITERS = 6'd32;

    function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] v, input logic en);
        return (en && v[DIV_W-1]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [DIV_W-1:0] div_neg_if(input logic [DIV_W-1:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/imuldiv_int_div_iterative_ctrl.sv
// Control for the iterative divider: FSM, iteration down-counter, val/rdy and
// datapath load/step/result-select strobes.
//
//  state | meaning
//  IDLE  | ready for a request; load datapath on val&rdy
//  CALC  | one restoring shift-subtract per cycle until count hits 0
//  DONE  | result valid, held until the response is taken
module imuldiv_int_div_iterative_ctrl
    import imuldiv_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_req_val,
    output logic o_req_rdy,
    output logic o_resp_val,
    input  logic i_resp_rdy,
    output logic o_load,
    output logic o_step,
    output logic o_res_sel
);

    div_state_e             r_state;
    div_state_e             w_next_state;
    logic [DIV_CNT_W-1:0]   r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DIV_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            DIV_ST_IDLE: if (i_req_val)        w_next_state = DIV_ST_CALC;
            DIV_ST_CALC: if (r_count == '0)    w_next_state = DIV_ST_DONE;
            DIV_ST_DONE: if (i_resp_rdy)       w_next_state = DIV_ST_IDLE;
            default:                           w_next_state = DIV_ST_IDLE;
        endcase
    end

    // Handshake outputs are qualified by reset so nothing is offered while held in reset.
    always_comb begin
        o_req_rdy  = reset_n && (r_state == DIV_ST_IDLE);
        o_resp_val = reset_n && (r_state == DIV_ST_DONE);
        o_load     = o_req_rdy && i_req_val;
        o_step     = (r_state == DIV_ST_CALC) && (r_count != '0);
        o_res_sel  = o_resp_val;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (o_load) begin
            r_count <= DIV_ITERS;
        end else if (o_step) begin
            r_count <= r_count - 6'd1;
        end
    end

endmodule

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle, val/rdy in and out.
// Define IMULDIV_DIV_SIGNED_EN to honour divreq_msg_fn (signed div/rem); otherwise unsigned only.
module imuldiv_int_div_iterative
    import imuldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        divreq_msg_fn,
    input  logic [31:0] divreq_msg_a,
    input  logic [31:0] divreq_msg_b,
    input  logic        divreq_val,
    output logic        divreq_rdy,
    output logic [63:0] divresp_msg_result,
    output logic        divresp_val,
    input  logic        divresp_rdy
);

    logic        w_load;
    logic        w_step;
    logic        w_res_sel;

    logic [63:0] r_rem_quot;
    logic [31:0] r_b;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_hi;
    logic        w_ge;
    logic [31:0] w_hi_next;
    logic [31:0] w_rem;
    logic [31:0] w_quo;

    imuldiv_int_div_iterative_ctrl u_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req_val  (divreq_val),
        .o_req_rdy  (divreq_rdy),
        .o_resp_val (divresp_val),
        .i_resp_rdy (divresp_rdy),
        .o_load     (w_load),
        .o_step     (w_step),
        .o_res_sel  (w_res_sel)
    );

`ifdef IMULDIV_DIV_SIGNED_EN
    logic w_signed;
    logic r_sign_q;
    logic r_sign_r;

    assign w_signed = (divreq_msg_fn == DIV_FN_SIGNED);
    assign w_abs_a  = div_abs(divreq_msg_a, w_signed);
    assign w_abs_b  = div_abs(divreq_msg_b, w_signed);

    // Divide by zero keeps the all-ones quotient; the remainder fixup restores a itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else if (w_load) begin
            r_sign_q <= w_signed && (divreq_msg_a[31] ^ divreq_msg_b[31]) && (divreq_msg_b != '0);
            r_sign_r <= w_signed && divreq_msg_a[31];
        end
    end

    assign w_rem = div_neg_if(r_rem_quot[63:32], r_sign_r);
    assign w_quo = div_neg_if(r_rem_quot[31:0],  r_sign_q);
`else
    logic w_unused_fn;

    assign w_unused_fn = divreq_msg_fn;
    assign w_abs_a     = divreq_msg_a;
    assign w_abs_b     = divreq_msg_b;
    assign w_rem       = r_rem_quot[63:32];
    assign w_quo       = r_rem_quot[31:0];
`endif

    // Partial remainder after the left shift; bit 32 is the bit shifted out of the top.
    assign w_hi      = r_rem_quot[63:31];
    assign w_ge      = (w_hi >= {1'b0, r_b});
    assign w_hi_next = w_ge ? (w_hi[31:0] - r_b) : w_hi[31:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem_quot <= '0;
            r_b        <= '0;
        end else if (w_load) begin
            r_rem_quot <= {32'd0, w_abs_a};
            r_b        <= w_abs_b;
        end else if (w_step) begin
            r_rem_quot <= {w_hi_next, r_rem_quot[30:0], w_ge};
        end
    end

    assign divresp_msg_result[RES_REM_MSB:RES_REM_LSB] = w_res_sel ? w_rem : '0;
    assign divresp_msg_result[RES_QUO_MSB:RES_QUO_LSB] = w_res_sel ? w_quo : '0;

endmodule
